// File: rtl/frame_swap_pkg.sv
// Shared types for the frame swap scheduler: FSM state encoding,
// counter width and a saturating-increment helper.
package frame_swap_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [0:0] {
    READY   = 1'b0,
    PENDING = 1'b1
  } state_e;

  // Increment v by one, never exceeding lim.
  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
    return (v >= lim) ? lim : cnt_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/frame_swap_sat_counter.sv
// Saturating up-counter with synchronous clear; used for both the
// hold counter and the stale-frame counter.
module frame_swap_sat_counter
  import frame_swap_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  // Clear wins over increment; increment stops at limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count, limit);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/frame_swap_scheduler.sv
// Double-buffer swap scheduler: accepts a loaded back buffer and flips
// banks at a frame boundary once the front buffer has been shown for at
// least MIN_HOLD completed frames.
// Optional macro FRAME_SWAP_STALE_EN adds the stale-frame detector.
module frame_swap_scheduler
  import frame_swap_pkg::*;
#(
  parameter int MIN_HOLD     = 1,
  parameter int STALE_FRAMES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_complete,
  input  logic             loaded,
  output logic             ready,
  output logic             flip,
  output logic             flip_pulse,
  output logic             dropped,
  output logic [CNT_W-1:0] swap_count,
  output logic             stale
);

  localparam cnt_t HOLD = cnt_t'(MIN_HOLD);

  // Reject out-of-range configurations at elaboration.
  if (MIN_HOLD < 1 || MIN_HOLD > 255) begin : g_bad_hold
    $error("MIN_HOLD out of range 1..255");
  end
  if (STALE_FRAMES < 1 || STALE_FRAMES > 255) begin : g_bad_stale
    $error("STALE_FRAMES out of range 1..255");
  end

  state_e state;
  state_e state_next;
  cnt_t   shown;
  logic   shown_full;
  logic   hold_met;
  logic   swap;

  frame_swap_sat_counter u_shown (
    .clk      (clk),
    .rst      (rst),
    .inc      (frame_complete),
    .clr      (swap),
    .limit    (HOLD),
    .count    (shown),
    .at_limit (shown_full)
  );

  // Swap qualifies when the frame being completed brings shown up to MIN_HOLD.
  always_comb begin
    hold_met   = shown_full | (sat_inc(shown, HOLD) == HOLD);
    swap       = (state == PENDING) && frame_complete && hold_met;
    state_next = state;
    if (swap) begin
      state_next = READY;
    end else if ((state == READY) && loaded) begin
      state_next = PENDING;
    end
  end

  // State, registered ready decode, bank select and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= READY;
      ready      <= 1'b1;
      flip       <= 1'b0;
      flip_pulse <= 1'b0;
      dropped    <= 1'b0;
      swap_count <= '0;
    end else begin
      state      <= state_next;
      ready      <= (state_next == READY);
      flip_pulse <= swap;
      dropped    <= (state == PENDING) && loaded;
      if (swap) begin
        flip       <= ~flip;
        swap_count <= swap_count + 1'b1;
      end
    end
  end

`ifdef FRAME_SWAP_STALE_EN
  cnt_t stale_cnt;

  frame_swap_sat_counter u_stale (
    .clk      (clk),
    .rst      (rst),
    .inc      (frame_complete),
    .clr      (swap),
    .limit    (cnt_t'(STALE_FRAMES)),
    .count    (stale_cnt),
    .at_limit (stale)
  );
`else
  assign stale = 1'b0;
`endif

endmodule
